// File: rtl/nibbler_pkg.sv
// Shared types and constants for the nibbler program-memory loader.
// Optional checksum states exist only with NIBBLER_LOADER_CKSUM_EN.
package nibbler_pkg;

  localparam int NIB_W = 4;
  localparam int PM_AW = 12;
  localparam int PM_DW = 8;

  localparam logic [NIB_W-1:0] SYNC_NIB_DEF = 4'hA;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DHI,
    S_DLO,
    S_WR,
`ifdef NIBBLER_LOADER_CKSUM_EN
    S_CKHI,
    S_CKLO,
`endif
    S_FIN
  } state_t;

endpackage

// File: rtl/nibble_shift12.sv
// Three-nibble MSB-first shift register with a third-nibble flag.
// Used for both the start address and the length fields.
module nibble_shift12
  import nibbler_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [NIB_W-1:0] i_nib,
  output logic [PM_AW-1:0] o_val,
  output logic             o_last
);

  logic [PM_AW-1:0] r_val;
  logic [1:0]       r_cnt;

  assign o_val  = r_val;
  assign o_last = (r_cnt == 2'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_val <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_val <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      r_val <= {r_val[PM_AW-NIB_W-1:0], i_nib};
      r_cnt <= o_last ? 2'd0 : r_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/nibbler_prog_loader.sv
// Nibble-stream loader for the nibbler 4096x8 program memory.
// Checksum verification built only with NIBBLER_LOADER_CKSUM_EN.
module nibbler_prog_loader
  import nibbler_pkg::*;
#(
  parameter logic [NIB_W-1:0] SYNC_NIB    = SYNC_NIB_DEF,
  parameter bit               HOLD_AT_POR = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NIB_W-1:0] host_nib,
  input  logic             host_valid,
  output logic             host_ready,
  output logic             pm_we,
  output logic [PM_AW-1:0] pm_addr,
  output logic [PM_DW-1:0] pm_wdata,
  output logic             cpu_reset,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t r_state;
  state_t w_next;

  logic             w_xfer;
  logic             w_sync_acc;
  logic             w_last_byte;
  logic             w_ready;
  logic             w_we;
  logic             w_busy;
  logic             w_done;
  logic             w_err;

  logic [PM_AW-1:0] w_addr_val;
  logic [PM_AW-1:0] w_len_val;
  logic             w_addr_last;
  logic             w_len_last;

  logic [NIB_W-1:0] r_hi;
  logic [PM_AW-1:0] r_bcnt;
  logic [PM_AW-1:0] r_pm_addr;
  logic [PM_DW-1:0] r_pm_wdata;
  logic             r_cpu_reset;

`ifdef NIBBLER_LOADER_CKSUM_EN
  logic [PM_DW-1:0] r_sum;
  logic [NIB_W-1:0] r_ckhi;
  logic             r_err;
  assign w_err = r_err;
`else
  assign w_err = 1'b0;
`endif

  assign w_xfer      = host_valid & w_ready;
  assign w_sync_acc  = w_xfer & (r_state == S_IDLE)
                     & (host_nib == SYNC_NIB);
  assign w_last_byte = (r_bcnt == w_len_val);

  nibble_shift12 u_addr (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_sync_acc),
    .i_en   (w_xfer & (r_state == S_ADDR)),
    .i_nib  (host_nib),
    .o_val  (w_addr_val),
    .o_last (w_addr_last)
  );

  nibble_shift12 u_len (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_sync_acc),
    .i_en   (w_xfer & (r_state == S_LEN)),
    .i_nib  (host_nib),
    .o_val  (w_len_val),
    .o_last (w_len_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_sync_acc)               w_next = S_ADDR;
      S_ADDR: if (w_xfer && w_addr_last)    w_next = S_LEN;
      S_LEN:  if (w_xfer && w_len_last)     w_next = S_DHI;
      S_DHI:  if (w_xfer)                   w_next = S_DLO;
      S_DLO:  if (w_xfer)                   w_next = S_WR;
`ifdef NIBBLER_LOADER_CKSUM_EN
      S_WR:   w_next = w_last_byte ? S_CKHI : S_DHI;
      S_CKHI: if (w_xfer)                   w_next = S_CKLO;
      S_CKLO: if (w_xfer)                   w_next = S_FIN;
`else
      S_WR:   w_next = w_last_byte ? S_FIN : S_DHI;
`endif
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b1;
    w_we    = 1'b0;
    w_busy  = (r_state != S_IDLE);
    w_done  = 1'b0;
    unique case (r_state)
      S_WR:  begin
        w_ready = 1'b0;
        w_we    = 1'b1;
      end
      S_FIN: begin
        w_ready = 1'b0;
        w_done  = ~w_err;
      end
      default: ;
    endcase
  end

  // pm_addr/pm_wdata latch at DLO so they are stable through WR and after.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi        <= '0;
      r_bcnt      <= '0;
      r_pm_addr   <= '0;
      r_pm_wdata  <= '0;
      r_cpu_reset <= HOLD_AT_POR;
    end else begin
      if (w_sync_acc) begin
        r_bcnt      <= '0;
        r_cpu_reset <= 1'b1;
      end
      if (w_xfer && r_state == S_DHI)
        r_hi <= host_nib;
      if (w_xfer && r_state == S_DLO) begin
        r_pm_addr  <= w_addr_val + r_bcnt;
        r_pm_wdata <= {r_hi, host_nib};
      end
      if (r_state == S_WR)
        r_bcnt <= r_bcnt + 12'd1;
      if (r_state == S_FIN)
        r_cpu_reset <= w_err;
    end
  end

`ifdef NIBBLER_LOADER_CKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum  <= '0;
      r_ckhi <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_sync_acc) begin
        r_sum <= '0;
        r_err <= 1'b0;
      end
      if (r_state == S_WR)
        r_sum <= r_sum + r_pm_wdata;
      if (w_xfer && r_state == S_CKHI)
        r_ckhi <= host_nib;
      if (w_xfer && r_state == S_CKLO
          && {r_ckhi, host_nib} != r_sum)
        r_err <= 1'b1;
    end
  end
`endif

  assign host_ready = w_ready;
  assign pm_we      = w_we;
  assign pm_addr    = r_pm_addr;
  assign pm_wdata   = r_pm_wdata;
  assign cpu_reset  = r_cpu_reset;
  assign busy       = w_busy;
  assign done       = w_done;
  assign err        = w_err;

endmodule

// File: tb/tb_nibbler_prog_loader.sv
// Directed bench for nibbler_prog_loader (default HOLD_AT_POR=1).
// Checksum cases compile in with NIBBLER_LOADER_CKSUM_EN.
module tb_nibbler_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  host_nib;
  logic        host_valid;
  logic        host_ready;
  logic        pm_we;
  logic [11:0] pm_addr;
  logic [7:0]  pm_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;
  int ndone = 0;
  int hr_bad = 0;
  logic [19:0] wq[$];

  nibbler_prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .host_nib   (host_nib),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .pm_we      (pm_we),
    .pm_addr    (pm_addr),
    .pm_wdata   (pm_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pm_we === 1'b1) begin
      wq.push_back({pm_addr, pm_wdata});
      if (host_ready !== 1'b0) hr_bad++;
    end
    if (done === 1'b1) ndone++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] n);
    int t;
    t = 0;
    host_nib   = n;
    host_valid = 1'b1;
    while (host_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("ready_timeout", {31'd0, host_ready}, 1);
    @(posedge clk);
    @(negedge clk);
    host_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int g);
    gap(g);
    send(b[7:4]);
    gap(g);
    send(b[3:0]);
  endtask

  task automatic hdr(input logic [11:0] a, input logic [11:0] l);
    send(4'hA);
    send(a[11:8]); send(a[7:4]); send(a[3:0]);
    send(l[11:8]); send(l[7:4]); send(l[3:0]);
  endtask

  task automatic ck(input logic [7:0] s);
`ifdef NIBBLER_LOADER_CKSUM_EN
    send(s[7:4]);
    send(s[3:0]);
`else
    if (s == 8'h00) gap(0);
`endif
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done"}, {31'd0, done}, 1);
    chk({tag, "_crst_fin"}, {31'd0, cpu_reset}, 1);
    @(negedge clk);
    chk({tag, "_crst_after"}, {31'd0, cpu_reset}, 0);
    chk({tag, "_busy_after"}, {31'd0, busy}, 0);
  endtask

  initial begin
    reset      = 1'b1;
    host_valid = 1'b0;
    host_nib   = 4'h0;
    gap(2);
    chk("rst_ready", {31'd0, host_ready}, 1);
    chk("rst_we",    {31'd0, pm_we}, 0);
    chk("rst_addr",  {20'd0, pm_addr}, 0);
    chk("rst_wdata", {24'd0, pm_wdata}, 0);
    chk("rst_busy",  {31'd0, busy}, 0);
    chk("rst_done",  {31'd0, done}, 0);
    chk("rst_err",   {31'd0, err}, 0);
    chk("rst_crst",  {31'd0, cpu_reset}, 1);
    reset = 1'b0;
    gap(1);

    // junk before sync
    send(4'h3);
    send(4'h7);
    gap(1);
    chk("junk_busy",  {31'd0, busy}, 0);
    chk("junk_ready", {31'd0, host_ready}, 1);
    chk("junk_nwr",   wq.size(), 0);

    // basic two-byte load at 0x010
    send(4'hA);
    chk("sync_busy", {31'd0, busy}, 1);
    chk("sync_crst", {31'd0, cpu_reset}, 1);
    send(4'h0); send(4'h1); send(4'h0);
    send(4'h0); send(4'h0); send(4'h1);
    send_byte(8'h45, 0);
    send_byte(8'hA3, 0);
    ck(8'hE8);
    wait_done("basic");
    chk("basic_nwr", wq.size(), 2);
    chk("basic_w0", {12'd0, wq[0]}, 32'h01045);
    chk("basic_w1", {12'd0, wq[1]}, 32'h011A3);
    chk("basic_ndone", ndone, 1);
    chk("basic_hold", {20'd0, pm_addr}, 32'h011);

    // address wrap
    wq.delete();
    hdr(12'hFFF, 12'h001);
    send_byte(8'h12, 1);
    send_byte(8'h34, 2);
    ck(8'h46);
    wait_done("wrap");
    chk("wrap_nwr", wq.size(), 2);
    chk("wrap_w0", {12'd0, wq[0]}, 32'hFFF12);
    chk("wrap_w1", {12'd0, wq[1]}, 32'h00034);
    chk("wrap_ndone", ndone, 2);

    // random gaps, sync value inside data
    wq.delete();
    hdr(12'h100, 12'h004);
    send_byte(8'h01, $urandom_range(0, 3));
    send_byte(8'hAA, $urandom_range(0, 3));
    send_byte(8'h5F, $urandom_range(0, 3));
    send_byte(8'hC3, $urandom_range(0, 3));
    send_byte(8'h7E, $urandom_range(0, 3));
    ck(8'h4B);
    wait_done("gaps");
    chk("gaps_nwr", wq.size(), 5);
    chk("gaps_w0", {12'd0, wq[0]}, 32'h10001);
    chk("gaps_w1", {12'd0, wq[1]}, 32'h101AA);
    chk("gaps_w2", {12'd0, wq[2]}, 32'h1025F);
    chk("gaps_w3", {12'd0, wq[3]}, 32'h103C3);
    chk("gaps_w4", {12'd0, wq[4]}, 32'h1047E);
    chk("gaps_hr", hr_bad, 0);

    // reset during DLO of second byte
    wq.delete();
    hdr(12'h200, 12'h002);
    send_byte(8'h56, 0);
    send(4'h7);
    #2 reset = 1'b1;
    #1;
    chk("mid_busy",  {31'd0, busy}, 0);
    chk("mid_ready", {31'd0, host_ready}, 1);
    chk("mid_we",    {31'd0, pm_we}, 0);
    chk("mid_addr",  {20'd0, pm_addr}, 0);
    chk("mid_wdata", {24'd0, pm_wdata}, 0);
    chk("mid_crst",  {31'd0, cpu_reset}, 1);
    gap(2);
    reset = 1'b0;
    gap(1);
    chk("mid_nwr", wq.size(), 1);
    chk("mid_w0", {12'd0, wq[0]}, 32'h20056);
    chk("mid_ndone", ndone, 3);
    wq.delete();
    hdr(12'h300, 12'h000);
    send_byte(8'h9C, 0);
    ck(8'h9C);
    wait_done("after");
    chk("after_nwr", wq.size(), 1);
    chk("after_w0", {12'd0, wq[0]}, 32'h3009C);
    chk("after_ndone", ndone, 4);

`ifdef NIBBLER_LOADER_CKSUM_EN
    hdr(12'h020, 12'h001);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    ck(8'h46);
    chk("ckok_err", {31'd0, err}, 0);
    wait_done("ckok");
    chk("ckok_ndone", ndone, 5);
    hdr(12'h020, 12'h001);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    ck(8'h47);
    gap(4);
    chk("ckbad_err",   {31'd0, err}, 1);
    chk("ckbad_ndone", ndone, 5);
    chk("ckbad_crst",  {31'd0, cpu_reset}, 1);
    send(4'hA);
    chk("ckbad_clr", {31'd0, err}, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
